// File: rtl/analog_io_sched.sv
// Round-robin transaction controller that time-shares one analog_io channel
// between NREQ requesters: drive, settle, capture, acknowledge.
module analog_io_sched #(
    parameter int BITS   = 16,
    parameter int NREQ   = 4,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*BITS-1:0] wdata,
    output logic [NREQ-1:0]      ack,
    output logic [BITS-1:0]      rdata,
    output logic                 busy,
    output logic                 io_en,
    output logic                 io_dir,
    output logic [BITS-1:0]      io_wdata,
    input  logic [BITS-1:0]      io_rdata
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD  = CNTW'(SETTLE - 1);
    localparam logic [IDXW-1:0] LAST_INIT = IDXW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [IDXW-1:0]   last_r;
    logic [IDXW-1:0]   idx_r;
    logic [IDXW-1:0]   win_s;
    logic              win_valid_s;
    logic [CNTW-1:0]   cnt_r;
    logic [NREQ-1:0]   ack_r;
    logic [BITS-1:0]   rdata_r;
    logic              busy_r;
    logic              io_en_r;
    logic              io_dir_r;
    logic [BITS-1:0]   io_wdata_r;
    logic [BITS-1:0]   wdata_a_s [NREQ];

    function automatic logic [IDXW-1:0] rr_slot(input logic [IDXW-1:0] base, input int k);
        return IDXW'((int'(base) + k) % NREQ);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
        logic [NREQ-1:0] v;
        v    = {NREQ{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    // Split the flat write-data bus into one word per requester
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wdata_a_s[i] = wdata[i*BITS +: BITS];
        end
    end

    // Round-robin winner: scanning downwards leaves the requester closest after last_r
    always_comb begin
        win_s       = last_r;
        win_valid_s = |req;
        for (int k = NREQ; k >= 1; k--) begin
            win_s = req[rr_slot(last_r, k)] ? rr_slot(last_r, k) : win_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    next_state_s = ST_SETTLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == {CNTW{1'b0}}) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end
            ST_CAPTURE: next_state_s = ST_ACK;
            ST_ACK:     next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Transaction datapath; outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r     <= LAST_INIT;
            idx_r      <= {IDXW{1'b0}};
            cnt_r      <= {CNTW{1'b0}};
            ack_r      <= {NREQ{1'b0}};
            rdata_r    <= {BITS{1'b0}};
            busy_r     <= 1'b0;
            io_en_r    <= 1'b0;
            io_dir_r   <= 1'b0;
            io_wdata_r <= {BITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        idx_r      <= win_s;
                        last_r     <= win_s;
                        cnt_r      <= CNT_LOAD;
                        io_dir_r   <= wr[win_s];
                        io_wdata_r <= wdata_a_s[win_s];
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r != {CNTW{1'b0}}) begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                // Capture for writes too, so the requester gets a readback
                ST_CAPTURE: rdata_r <= io_rdata;
                ST_ACK: begin
                end
                default: begin
                end
            endcase
            io_en_r <= (next_state_s == ST_SETTLE) || (next_state_s == ST_CAPTURE);
            busy_r  <= (next_state_s != ST_IDLE);
            ack_r   <= (next_state_s == ST_ACK) ? onehot(idx_r) : {NREQ{1'b0}};
        end
    end

    assign ack      = ack_r;
    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign io_en    = io_en_r;
    assign io_dir   = io_dir_r;
    assign io_wdata = io_wdata_r;

endmodule

// File: tb/tb_analog_io_sched.sv
// Self-checking bench for analog_io_sched: directed scenarios plus randomized
// traffic against a cycle-arithmetic reference model.
module tb_analog_io_sched;

    localparam int BITS   = 16;
    localparam int NREQ   = 4;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        io_en;
    logic        io_dir;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    analog_io_sched #(.BITS(BITS), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .io_en(io_en),
        .io_dir(io_dir), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference arbitration: first requester after 'last', wrapping
    function automatic int rr_pick(input int last, input logic [3:0] r);
        logic [3:0] s;
        for (int k = 1; k <= NREQ; k++) begin
            s = r >> ((last + k) % NREQ);
            if (s[0]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        req = 4'h0; wr = 4'h0; wdata = 64'h0; io_rdata = 16'h0;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (io_en !== 1'b0)      begin n_err++; $display("FAIL reset_io_en got=%b exp=0", io_en); end
        n_cmp++; if (io_dir !== 1'b0)     begin n_err++; $display("FAIL reset_io_dir got=%b exp=0", io_dir); end
        n_cmp++; if (io_wdata !== 16'h0)  begin n_err++; $display("FAIL reset_io_wdata got=%h exp=0", io_wdata); end
        n_cmp++; if (rdata !== 16'h0)     begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_cmp++; if (ack !== 4'h0)        begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int en_cnt = 0;
        logic [3:0] exp_ack;
        do_reset();
        req = 4'b0001; wr = 4'b0000; wdata = 64'h0; io_rdata = 16'h1234;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (io_en === 1'b1) en_cnt++;
            exp_ack = (t == 6) ? 4'b0001 : 4'b0000;
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL read_ack t=%0d got=%b exp=%b", t, ack, exp_ack); end
            if (t == 6) begin
                n_cmp++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL read_rdata got=%h exp=1234", rdata); end
                req = 4'b0000;
            end
        end
        n_cmp++; if (en_cnt != 5)    begin n_err++; $display("FAIL read_en_cycles got=%0d exp=5", en_cnt); end
        n_cmp++; if (io_dir !== 1'b0) begin n_err++; $display("FAIL read_io_dir got=%b exp=0", io_dir); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL read_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_write_idle();
        logic [15:0] rb;
        do_reset();
        rb = 16'($urandom);
        req = 4'b0100; wr = 4'b0100; io_rdata = rb;
        wdata = {$urandom, $urandom};
        wdata[47:32] = 16'hBEEF;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t <= 5) begin
                n_cmp++; if (io_en !== 1'b1)        begin n_err++; $display("FAIL wr_io_en t=%0d got=%b exp=1", t, io_en); end
                n_cmp++; if (io_dir !== 1'b1)       begin n_err++; $display("FAIL wr_io_dir t=%0d got=%b exp=1", t, io_dir); end
                n_cmp++; if (io_wdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_io_wdata t=%0d got=%h exp=beef", t, io_wdata); end
            end else begin
                n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL wr_ack got=%b exp=0100", ack); end
                n_cmp++; if (rdata !== rb)    begin n_err++; $display("FAIL wr_readback got=%h exp=%h", rdata, rb); end
                req = 4'b0000;
            end
        end
        for (int t = 0; t < 3; t++) tick();
        n_cmp++; if (io_en !== 1'b0)        begin n_err++; $display("FAIL wr_idle_en got=%b exp=0", io_en); end
        n_cmp++; if (io_dir !== 1'b1)       begin n_err++; $display("FAIL wr_idle_dir got=%b exp=1", io_dir); end
        n_cmp++; if (io_wdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_idle_wdata got=%h exp=beef", io_wdata); end
    endtask

    task automatic test_contention();
        int acyc[8];
        logic [3:0] aval[8];
        int n_ack = 0;
        logic [3:0] e;
        do_reset();
        req = 4'b1111; wr = 4'($urandom); wdata = {$urandom, $urandom};
        for (int t = 1; t <= 36; t++) begin
            tick();
            n_cmp++; if (!$onehot0(ack)) begin n_err++; $display("FAIL cont_onehot t=%0d got=%b", t, ack); end
            if (ack !== 4'h0) begin
                if (n_ack < 8) begin acyc[n_ack] = t; aval[n_ack] = ack; end
                n_ack++;
            end
        end
        req = 4'h0;
        n_cmp++; if (n_ack != 5) begin n_err++; $display("FAIL cont_count got=%0d exp=5", n_ack); end
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << (i % 4);
            n_cmp++; if (aval[i] !== e)       begin n_err++; $display("FAIL cont_order i=%0d got=%b exp=%b", i, aval[i], e); end
            n_cmp++; if (acyc[i] != 6 + 7*i)  begin n_err++; $display("FAIL cont_spacing i=%0d got=%0d exp=%0d", i, acyc[i], 6 + 7*i); end
        end
    endtask

    task automatic test_fairness();
        int acyc[8];
        logic [3:0] aval[8];
        int n_ack = 0;
        logic [3:0] e;
        do_reset();
        req = 4'b0010; wr = 4'h0; wdata = {$urandom, $urandom};
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (ack !== 4'h0) begin
                if (n_ack < 8) begin acyc[n_ack] = t; aval[n_ack] = ack; end
                n_ack++;
            end
            if (t == 2) req[3] = 1'b1;
            if (ack[3] === 1'b1) req[3] = 1'b0;
        end
        req = 4'h0;
        n_cmp++; if (n_ack != 3) begin n_err++; $display("FAIL fair_count got=%0d exp=3", n_ack); end
        for (int i = 0; i < 3; i++) begin
            e = (i == 1) ? 4'b1000 : 4'b0010;
            n_cmp++; if (aval[i] !== e)      begin n_err++; $display("FAIL fair_order i=%0d got=%b exp=%b", i, aval[i], e); end
            n_cmp++; if (acyc[i] != 6 + 7*i) begin n_err++; $display("FAIL fair_cycle i=%0d got=%0d exp=%0d", i, acyc[i], 6 + 7*i); end
        end
    endtask

    task automatic test_withdraw();
        int pulses = 0;
        int first = -1;
        int others = 0;
        logic [15:0] rb;
        do_reset();
        rb = 16'($urandom);
        req = 4'b0001; wr = 4'h0; io_rdata = rb;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (ack[0] === 1'b1) begin pulses++; if (first < 0) first = t; end
            if (ack[3:1] !== 3'b000) others++;
            if (t == 2) req = 4'h0;
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL wd_pulses got=%0d exp=1", pulses); end
        n_cmp++; if (first != 6)  begin n_err++; $display("FAIL wd_ack_cycle got=%0d exp=6", first); end
        n_cmp++; if (others != 0) begin n_err++; $display("FAIL wd_other_acks got=%0d exp=0", others); end
        n_cmp++; if (rdata !== rb) begin n_err++; $display("FAIL wd_rdata got=%h exp=%h", rdata, rb); end
    endtask

    task automatic test_reset_midop();
        int stray = 0;
        int first = -1;
        logic [3:0] fval = 4'h0;
        do_reset();
        req = 4'b0010; wr = 4'b0010; wdata = {$urandom, $urandom};
        for (int t = 0; t < 3; t++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (io_en !== 1'b0)     begin n_err++; $display("FAIL rmid_io_en got=%b exp=0", io_en); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_cmp++; if (ack !== 4'h0)       begin n_err++; $display("FAIL rmid_ack got=%b exp=0", ack); end
        n_cmp++; if (io_dir !== 1'b0)    begin n_err++; $display("FAIL rmid_io_dir got=%b exp=0", io_dir); end
        n_cmp++; if (io_wdata !== 16'h0) begin n_err++; $display("FAIL rmid_io_wdata got=%h exp=0", io_wdata); end
        req = 4'h0;
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (ack !== 4'h0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL rmid_stray_ack got=%0d exp=0", stray); end
        req = 4'b0011; wr = 4'h0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (ack !== 4'h0 && first < 0) begin first = t; fval = ack; end
        end
        req = 4'h0;
        n_cmp++; if (fval !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant got=%b exp=0001", fval); end
        n_cmp++; if (first != 6)       begin n_err++; $display("FAIL rmid_latency got=%0d exp=6", first); end
    endtask

    task automatic test_random();
        int t0 = -100;
        int w = -1;
        int free_at = 0;
        int m_last = NREQ - 1;
        logic        exp_dir = 1'b0;
        logic [15:0] exp_wdata = 16'h0;
        logic [15:0] exp_rdata = 16'h0;
        logic [3:0]  pend = 4'h0;
        logic [3:0]  pwr = 4'h0;
        logic [3:0]  newm;
        logic [3:0]  exp_ack;
        logic [3:0]  wsh;
        logic [63:0] pdata = 64'h0;
        logic [63:0] dmask;
        logic [63:0] tmp;
        logic        exp_en;
        logic        exp_busy;
        do_reset();
        req = 4'h0; wr = 4'h0; wdata = 64'h0; io_rdata = 16'h0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            tick();
            exp_en   = (w >= 0) && (cyc >= t0 + 1) && (cyc <= t0 + SETTLE + 1);
            exp_busy = (w >= 0) && (cyc >= t0 + 1) && (cyc <= t0 + SETTLE + 2);
            exp_ack  = 4'h0;
            if (w >= 0 && cyc == t0 + SETTLE + 2) exp_ack = 4'b0001 << w;
            n_cmp++; if (io_en !== exp_en)       begin n_err++; $display("FAIL rnd_io_en cyc=%0d got=%b exp=%b", cyc, io_en, exp_en); end
            n_cmp++; if (busy !== exp_busy)      begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            n_cmp++; if (ack !== exp_ack)        begin n_err++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack); end
            n_cmp++; if (io_dir !== exp_dir)     begin n_err++; $display("FAIL rnd_io_dir cyc=%0d got=%b exp=%b", cyc, io_dir, exp_dir); end
            n_cmp++; if (io_wdata !== exp_wdata) begin n_err++; $display("FAIL rnd_io_wdata cyc=%0d got=%h exp=%h", cyc, io_wdata, exp_wdata); end
            n_cmp++; if (rdata !== exp_rdata)    begin n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata); end

            pend = pend & ~exp_ack;
            newm = 4'h0;
            dmask = 64'h0;
            for (int i = 0; i < NREQ; i++) begin
                if (((pend >> i) & 4'h1) == 4'h0 && !(w == i && cyc < t0 + SETTLE + 2)
                    && $urandom_range(0, 3) == 0) begin
                    newm  = newm | (4'b0001 << i);
                    dmask = dmask | (64'hFFFF << (i * 16));
                end
            end
            pend  = pend | newm;
            pwr   = (pwr & ~newm) | (4'($urandom) & newm);
            pdata = (pdata & ~dmask) | ({$urandom, $urandom} & dmask);
            if (w >= 0 && cyc > t0 && cyc <= t0 + SETTLE && $urandom_range(0, 15) == 0)
                pend = pend & ~(4'b0001 << w);

            req = pend; wr = pwr; wdata = pdata; io_rdata = 16'($urandom);
            if (w >= 0 && cyc == t0 + SETTLE + 1) exp_rdata = io_rdata;

            if (cyc >= free_at && req != 4'h0) begin
                w         = rr_pick(m_last, req);
                t0        = cyc;
                m_last    = w;
                free_at   = cyc + SETTLE + 3;
                wsh       = wr >> w;
                exp_dir   = wsh[0];
                tmp       = wdata >> (w * 16);
                exp_wdata = tmp[15:0];
            end
        end
        req = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'h0; wr = 4'h0; wdata = 64'h0; io_rdata = 16'h0;
        test_reset();
        test_read();
        test_write_idle();
        test_contention();
        test_fairness();
        test_withdraw();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
